// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles received bytes into big-endian instruction words and writes them to instruction memory
module program_loader #(
    parameter int NB_DATA   = 32,
    parameter int NB_BYTE   = 8,
    parameter int MEM_DEPTH = 256,
    parameter int NB_ADDR   = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_loading,
    output logic               o_done,
    output logic               o_overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEM_DEPTH - 1);

    logic [1:0]         state;
    logic [1:0]         byte_cnt;
    logic [NB_DATA-1:0] word;
    logic [NB_ADDR-1:0] addr;
    logic               done;
    logic               overflow;
    logic [NB_DATA-1:0] shifted;
    logic               halt;

    // First byte received ends up in the top byte after four shifts.
    assign shifted = {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
    assign halt    = (word[NB_DATA-1 -: 6] == 6'b111111);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            word     <= '0;
            addr     <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state    <= RECV;
                        byte_cnt <= 2'd0;
                        word     <= '0;
                        addr     <= '0;
                        done     <= 1'b0;
                        overflow <= 1'b0;
                    end
                end
                RECV: begin
                    if (i_rx_valid) begin
                        word     <= shifted;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (halt) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        overflow <= 1'b0;
                    end else if (addr == LAST_ADDR) begin
                        // Memory full without a halt word: stop rather than wrap.
                        state    <= DONE;
                        done     <= 1'b1;
                        overflow <= 1'b1;
                    end else begin
                        state <= RECV;
                        addr  <= addr + 1'b1;
                        // A byte arriving during the write cycle starts the next word.
                        if (i_rx_valid) begin
                            word     <= shifted;
                            byte_cnt <= 2'd1;
                        end else begin
                            byte_cnt <= 2'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_wr_en    = (state == WRITE);
    assign o_wr_addr  = addr;
    assign o_wr_data  = word;
    assign o_loading  = (state == RECV) || (state == WRITE);
    assign o_done     = done;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven and sequence checks for program_loader
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        wr_en,   s_wr_en;
    logic [31:0] wr_addr, s_wr_addr;
    logic [31:0] wr_data, s_wr_data;
    logic        loading, s_loading;
    logic        done,    s_done;
    logic        ovf,     s_ovf;

    int tests = 0;
    int fails = 0;

    program_loader dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_loading  (loading),
        .o_done     (done),
        .o_overflow (ovf)
    );

    program_loader #(.MEM_DEPTH(4)) dut_small (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_wr_en    (s_wr_en),
        .o_wr_addr  (s_wr_addr),
        .o_wr_data  (s_wr_data),
        .o_loading  (s_loading),
        .o_done     (s_done),
        .o_overflow (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        wr_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        loading;
        logic        done;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d,
                                input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic l, input logic dn, input logic o);
        vec_t r;
        r.start = s; r.valid = v; r.data = d; r.wr_en = we; r.addr = a;
        r.wdata = wd; r.loading = l; r.done = dn; r.ovf = o;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start    = s;
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " wr_en"},   {31'd0, wr_en},   32'd0);
        check({tag, " wr_addr"}, wr_addr,          32'd0);
        check({tag, " wr_data"}, wr_data,          32'd0);
        check({tag, " loading"}, {31'd0, loading}, 32'd0);
        check({tag, " done"},    {31'd0, done},    32'd0);
        check({tag, " ovf"},     {31'd0, ovf},     32'd0);
    endtask

    initial begin
        logic [7:0]  bytes_a [4];
        logic [31:0] words_s [4];

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Bytes before start, start with byte, start during RECV, write-cycle byte, halt, restart.
        vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hBB, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h8C, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h22, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h99, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h04, 1, 0, 32'h8C220004, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h49, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h60, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h23, 1, 1, 32'h00496023, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFC, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 2, 32'hFC000000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h22, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h34, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h56, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h78, 1, 0, 32'h12345678, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].start, vecs[i].valid, vecs[i].data);
            check($sformatf("v%0d wr_en", i),   {31'd0, wr_en},   {31'd0, vecs[i].wr_en});
            check($sformatf("v%0d loading", i), {31'd0, loading}, {31'd0, vecs[i].loading});
            check($sformatf("v%0d done", i),    {31'd0, done},    {31'd0, vecs[i].done});
            check($sformatf("v%0d ovf", i),     {31'd0, ovf},     {31'd0, vecs[i].ovf});
            if (vecs[i].wr_en) begin
                check($sformatf("v%0d wr_addr", i), wr_addr, vecs[i].addr);
                check($sformatf("v%0d wr_data", i), wr_data, vecs[i].wdata);
            end
        end

        // Reset in the middle of a word: immediate clear, partial word dropped.
        step(0, 1, 8'hAB);
        step(0, 1, 8'hCD);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h00);
        bytes_a = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int b = 0; b < 4; b++) begin
            step(0, 1, bytes_a[b]);
            check($sformatf("rl b%0d wr_en", b), {31'd0, wr_en}, (b == 3) ? 32'd1 : 32'd0);
        end
        check("rl wr_addr", wr_addr, 32'd0);
        check("rl wr_data", wr_data, 32'hDEADBEEF);

        // Overflow on the four-word instance.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 8'h00);
        words_s = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 4; b++) begin
                step(0, 1, words_s[w][31 - 8*b -: 8]);
            end
            check($sformatf("ov w%0d wr_en", w),   {31'd0, s_wr_en}, 32'd1);
            check($sformatf("ov w%0d wr_addr", w), s_wr_addr, w);
            check($sformatf("ov w%0d wr_data", w), s_wr_data, words_s[w]);
            step(0, 0, 8'h00);
            check($sformatf("ov w%0d wr_en off", w), {31'd0, s_wr_en}, 32'd0);
        end
        check("ov done",    {31'd0, s_done},    32'd1);
        check("ov ovf",     {31'd0, s_ovf},     32'd1);
        check("ov loading", {31'd0, s_loading}, 32'd0);
        for (int b = 0; b < 5; b++) begin
            step(0, 1, 8'h40 + 8'(b));
            check($sformatf("ov extra b%0d wr_en", b), {31'd0, s_wr_en}, 32'd0);
        end
        check("ov done hold", {31'd0, s_done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
